pipelined_processor: RTL and testbench



---
 rtl/pp_pkg.sv | 35 +++
 rtl/pp_alu.sv | 26 ++
 rtl/pipelined_processor.sv | 113 +++++++++++
 tb/tb_pipelined_processor.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pp_pkg.sv
// Shared definitions for the three-stage pipelined_processor core:
// opcodes, instruction field positions, NOP encoding and default reset PC.
package pp_pkg;

    localparam int unsigned OP_HI = 15;
    localparam int unsigned OP_LO = 11;
    localparam int unsigned RD_HI = 10;
    localparam int unsigned RD_LO = 8;
    localparam int unsigned RS_HI = 7;
    localparam int unsigned RS_LO = 5;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00101;
    localparam logic [4:0] OP_AND = 5'b00110;
    localparam logic [4:0] OP_OR  = 5'b00111;
    localparam logic [4:0] OP_NOT = 5'b01000;
    localparam logic [4:0] OP_INC = 5'b01001;
    localparam logic [4:0] OP_DEC = 5'b01010;
    localparam logic [4:0] OP_MOV = 5'b01100;

    localparam logic [15:0] NOP_INSTR        = 16'h0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0020;

    // Opcodes outside the defined set retire as NOPs and write nothing.
    function automatic logic op_writes(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_NOT, OP_INC, OP_DEC, OP_MOV: op_writes = 1'b1;
            OP_NOP:                         op_writes = 1'b0;
            default:                        op_writes = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pp_alu.sv
// Combinational 16-bit ALU for pipelined_processor; a = rd operand, b = rs operand.
module pp_alu
    import pp_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_INC:  y = a + 16'd1;
            OP_DEC:  y = a - 16'd1;
            OP_MOV:  y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_processor.sv
// Three-stage in-order 16-bit core (fetch, decode/read, ALU/writeback).
// Optional EX/WB forwarding enabled by defining PP_FORWARDING_EN.
module pipelined_processor
    import pp_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  write_addr,
    input  logic [15:0] write_data,
    input  logic        write_en,
    output logic [15:0] result,
    input  logic        write_enable_fm,
    input  logic        rst_fm,
    input  logic [15:0] write_data_fm,
    input  logic [31:0] write_addr_fm
);

    localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

    logic [15:0] imem [IMEM_DEPTH];
    logic [15:0] regs [8];
    logic [31:0] pc;
    logic [15:0] fetch_instr;
    logic [4:0]  if_op;
    logic [2:0]  if_rd;
    logic [2:0]  if_rs;
    logic [4:0]  ex_op;
    logic [2:0]  ex_rd;
    logic [15:0] ex_a;
    logic [15:0] ex_b;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [15:0] alu_y;
    logic        ex_wr;

    // Instruction memory load port is independent of the core reset.
    always_ff @(posedge clk) begin
        if (rst_fm) begin
            for (int unsigned i = 0; i < IMEM_DEPTH; i++) imem[i] <= '0;
        end else if (write_enable_fm && (write_addr_fm < 32'(IMEM_DEPTH))) begin
            imem[write_addr_fm[AW-1:0]] <= write_data_fm;
        end
    end

    assign fetch_instr = (pc < 32'(IMEM_DEPTH)) ? imem[pc[AW-1:0]] : NOP_INSTR;
    assign ex_wr       = op_writes(ex_op);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            if_op  <= NOP_INSTR[OP_HI:OP_LO];
            if_rd  <= '0;
            if_rs  <= '0;
            ex_op  <= NOP_INSTR[OP_HI:OP_LO];
            ex_rd  <= '0;
            ex_a   <= '0;
            ex_b   <= '0;
            result <= '0;
        end else begin
            pc     <= pc + 32'd1;
            if_op  <= fetch_instr[OP_HI:OP_LO];
            if_rd  <= fetch_instr[RD_HI:RD_LO];
            if_rs  <= fetch_instr[RS_HI:RS_LO];
            ex_op  <= if_op;
            ex_rd  <= if_rd;
            ex_a   <= regs[if_rd];
            ex_b   <= regs[if_rs];
            if (ex_wr) result <= alu_y;
        end
    end

    // Later assignment wins: external write overrides writeback to the same register.
    always_ff @(posedge clk) begin
        if (!reset && ex_wr) regs[ex_rd] <= alu_y;
        if (write_en)        regs[write_addr] <= write_data;
    end

`ifdef PP_FORWARDING_EN
    logic [2:0] ex_rs;
    logic       fwd_valid;
    logic [2:0] fwd_rd;

    // result holds the previous writer's value; invalid if an external write replaced it.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs     <= '0;
            fwd_valid <= 1'b0;
            fwd_rd    <= '0;
        end else begin
            ex_rs     <= if_rs;
            fwd_valid <= ex_wr && !(write_en && (write_addr == ex_rd));
            fwd_rd    <= ex_rd;
        end
    end

    assign op_a = (fwd_valid && (fwd_rd == ex_rd)) ? result : ex_a;
    assign op_b = (fwd_valid && (fwd_rd == ex_rs)) ? result : ex_b;
`else
    assign op_a = ex_a;
    assign op_b = ex_b;
`endif

    pp_alu u_alu (
        .op (ex_op),
        .a  (op_a),
        .b  (op_b),
        .y  (alu_y)
    );

endmodule

// File: tb/tb_pipelined_processor.sv
// Directed self-checking bench for pipelined_processor (honours PP_FORWARDING_EN).
module tb_pipelined_processor;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  write_addr;
    logic [15:0] write_data;
    logic        write_en;
    logic [15:0] result;
    logic        write_enable_fm;
    logic        rst_fm;
    logic [15:0] write_data_fm;
    logic [31:0] write_addr_fm;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    pipelined_processor #(
        .IMEM_DEPTH (64),
        .RESET_PC   (32'h0000_0020)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .write_addr      (write_addr),
        .write_data      (write_data),
        .write_en        (write_en),
        .result          (result),
        .write_enable_fm (write_enable_fm),
        .rst_fm          (rst_fm),
        .write_data_fm   (write_data_fm),
        .write_addr_fm   (write_addr_fm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_imem();
        rst_fm = 1'b1;
        tick();
        rst_fm = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [15:0] d);
        write_enable_fm = 1'b1;
        write_addr_fm   = a;
        write_data_fm   = d;
        tick();
        write_enable_fm = 1'b0;
    endtask

    task automatic preload(input logic [2:0] r, input logic [15:0] d);
        write_en   = 1'b1;
        write_addr = r;
        write_data = d;
        tick();
        write_en   = 1'b0;
    endtask

    task automatic test_load_fetch();
        logic [15:0] exp;
        reset = 1'b1;
        clear_imem();
        load_word(32'h20, 16'h65BF);
        load_word(32'h21, 16'h25BF);
        load_word(32'h22, 16'h65BF);
        load_word(32'h60, 16'hDEAD);  // out of range, must be ignored
        for (int i = 0; i < 64; i++) begin
            exp = (i == 32) ? 16'h65BF : (i == 33) ? 16'h25BF : (i == 34) ? 16'h65BF : 16'h0000;
            total_cnt++;
            if (dut.imem[i] !== exp)
                $display("FAIL imem_word[%0d]: got %h expected %h", i, dut.imem[i], exp);
            else pass_cnt++;
        end
        rst_fm = 1'b1; write_enable_fm = 1'b1; write_addr_fm = 32'h21; write_data_fm = 16'h1234;
        tick();
        rst_fm = 1'b0; write_enable_fm = 1'b0;
        total_cnt++;
        if (dut.imem[33] !== 16'h0000) $display("FAIL rst_fm_priority: got %h expected 0000", dut.imem[33]);
        else pass_cnt++;
        total_cnt++;
        if (dut.imem[32] !== 16'h0000) $display("FAIL rst_fm_clear: got %h expected 0000", dut.imem[32]);
        else pass_cnt++;
        load_word(32'h20, 16'h65BF);
        load_word(32'h21, 16'h25BF);
        load_word(32'h22, 16'h65BF);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        preload(3'd5, 16'd3);
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL reset_result: got %h expected 0000", result);
        else pass_cnt++;
        reset = 1'b0;
        tick(); tick();
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL edge2_result: got %h expected 0000", result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (result !== 16'h0003) $display("FAIL edge3_mov: got %h expected 0003", result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (result !== 16'h0006) $display("FAIL edge4_add: got %h expected 0006", result);
        else pass_cnt++;
    endtask

    task automatic test_distance1();
        logic [15:0] exp;
`ifdef PP_FORWARDING_EN
        exp = 16'h0006;
`else
        exp = 16'h0003;
`endif
        tick();
        total_cnt++;
        if (result !== exp) $display("FAIL dist1_result: got %h expected %h", result, exp);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[5] !== exp) $display("FAIL dist1_r5: got %h expected %h", dut.regs[5], exp);
        else pass_cnt++;
    endtask

    task automatic test_rf_priority();
        reset = 1'b1;
        clear_imem();
        load_word(32'h20, 16'h4D00);  // INC R5
        load_word(32'h22, 16'h66A0);  // MOV R6,R5
        preload(3'd5, 16'd3);
        reset = 1'b0;
        tick(); tick();
        preload(3'd5, 16'h00AA);      // coincides with INC R5 writeback at edge 3
        total_cnt++;
        if (result !== 16'h0004) $display("FAIL prio_result: got %h expected 0004", result);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[5] !== 16'h00AA) $display("FAIL prio_r5: got %h expected 00aa", dut.regs[5]);
        else pass_cnt++;
        tick();
        preload(3'd7, 16'h0077);      // coincides with MOV R6 writeback at edge 5
        total_cnt++;
        if (result !== 16'h00AA) $display("FAIL prio_mov: got %h expected 00aa", result);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[6] !== 16'h00AA) $display("FAIL dual_r6: got %h expected 00aa", dut.regs[6]);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[7] !== 16'h0077) $display("FAIL dual_r7: got %h expected 0077", dut.regs[7]);
        else pass_cnt++;
    endtask

    task automatic test_wrap_boundary();
        reset = 1'b1;
        clear_imem();
        load_word(32'h20, 16'h4B00);  // INC R3
        load_word(32'h21, 16'h2140);  // ADD R1,R2
        load_word(32'h3F, 16'h4C00);  // INC R4, last in-range word
        load_word(32'h00, 16'h5400);  // DEC R4, reachable only if fetch wraps
        load_word(32'h01, 16'h5400);
        preload(3'd1, 16'hFFFF);
        preload(3'd2, 16'h0001);
        preload(3'd3, 16'h0004);
        preload(3'd4, 16'h0009);
        reset = 1'b0;
        tick(); tick(); tick();
        total_cnt++;
        if (result !== 16'h0005) $display("FAIL inc_r3: got %h expected 0005", result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL add_wrap: got %h expected 0000", result);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[1] !== 16'h0000) $display("FAIL add_wrap_r1: got %h expected 0000", dut.regs[1]);
        else pass_cnt++;
        for (int i = 0; i < 30; i++) tick();
        total_cnt++;
        if (result !== 16'h000A) $display("FAIL last_word: got %h expected 000a", result);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) tick();
        total_cnt++;
        if (result !== 16'h000A) $display("FAIL pc_beyond_hold: got %h expected 000a", result);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[4] !== 16'h000A) $display("FAIL pc_beyond_r4: got %h expected 000a", dut.regs[4]);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        clear_imem();
        load_word(32'h20, 16'h4C00);
        load_word(32'h22, 16'h4C00);
        load_word(32'h24, 16'h4C00);
        preload(3'd4, 16'h0000);
        reset = 1'b0;
        tick(); tick(); tick();
        total_cnt++;
        if (result !== 16'h0001) $display("FAIL mid_first: got %h expected 0001", result);
        else pass_cnt++;
        tick();
        reset = 1'b1;                 // flushes INC at 0x22 just before its writeback
        tick();
        reset = 1'b0;
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL mid_reset_result: got %h expected 0000", result);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[4] !== 16'h0001) $display("FAIL mid_flush_r4: got %h expected 0001", dut.regs[4]);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (result !== 16'h0000) $display("FAIL mid_refill: got %h expected 0000", result);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (result !== 16'h0002) $display("FAIL refetch_0x20: got %h expected 0002", result);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (result !== 16'h0003) $display("FAIL refetch_0x22: got %h expected 0003", result);
        else pass_cnt++;
        total_cnt++;
        if (dut.regs[4] !== 16'h0003) $display("FAIL refetch_r4: got %h expected 0003", dut.regs[4]);
        else pass_cnt++;
    endtask

    initial begin
        reset           = 1'b1;
        write_addr      = '0;
        write_data      = '0;
        write_en        = 1'b0;
        write_enable_fm = 1'b0;
        rst_fm          = 1'b0;
        write_data_fm   = '0;
        write_addr_fm   = '0;
        tick(); tick();
        test_load_fetch();
        test_reset();
        test_distance1();
        test_rf_priority();
        test_wrap_boundary();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
